// File: rtl/native_ram_slave_pkg.sv
// Shared definitions for the native RAM slave: FSM encoding, memory depth
// default and the byte-offset helper used to derive the word index.
package native_ram_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_MEM_ADDR_WIDTH = 10;

    function automatic int byte_off_bits(input int strb_width);
        return (strb_width > 1) ? $clog2(strb_width) : 0;
    endfunction

endpackage

// File: rtl/native_ram_bytewe.sv
// Single-port RAM with per-byte write enables and a registered read port.
// The read returns the word as it was before any same-edge write.
module native_ram_bytewe #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [STRB_WIDTH-1:0] we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

    // Contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/native_ram_slave.sv
// Native-interface RAM slave with programmable wait states.
// Optional out-of-range detection and oor_err flag under NATIVE_RAM_OOR_EN.
//
// state | meaning
// IDLE  | waiting for native_valid; request latched on acceptance
// WAIT  | counting down wait states; memory accessed when counter hits 0
// RESP  | native_ready high for this single cycle, rdata valid
module native_ram_slave
    import native_ram_slave_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH,
    parameter int WAIT_CYCLES    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  native_valid,
    output logic                  native_ready,
    input  logic [ADDR_WIDTH-1:0] native_addr,
    input  logic [DATA_WIDTH-1:0] native_wdata,
    input  logic [STRB_WIDTH-1:0] native_wstrb,
    output logic [DATA_WIDTH-1:0] native_rdata
`ifdef NATIVE_RAM_OOR_EN
    ,
    output logic                  oor_err
`endif
);

    localparam int         OFF       = byte_off_bits(STRB_WIDTH);
    localparam logic [7:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

    state_t                    state, state_nxt;
    logic [7:0]                wait_cnt;
    logic [MEM_ADDR_WIDTH-1:0] idx_in, idx_q, ram_idx;
    logic [DATA_WIDTH-1:0]     wdata_q, ram_wdata, ram_rdata;
    logic [STRB_WIDTH-1:0]     wstrb_q, ram_wstrb, ram_we;
    logic                      accept, mem_en;
    logic                      unused_addr;

    assign idx_in      = native_addr[MEM_ADDR_WIDTH+OFF-1 : OFF];
    assign unused_addr = ^native_addr;
    assign accept      = (state == IDLE) && native_valid;

    // With zero wait states the access happens on the acceptance edge,
    // before the latches are loaded, so the live request is used.
    assign ram_idx   = (state == IDLE) ? idx_in       : idx_q;
    assign ram_wdata = (state == IDLE) ? native_wdata : wdata_q;
    assign ram_wstrb = (state == IDLE) ? native_wstrb : wstrb_q;

    always_comb begin
        state_nxt    = state;
        mem_en       = 1'b0;
        native_ready = 1'b0;
        case (state)
            IDLE: begin
                if (native_valid) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = RESP;
                        mem_en    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 8'd0) begin
                    state_nxt = RESP;
                    mem_en    = 1'b1;
                end
            end
            RESP: begin
                native_ready = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            mem_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            idx_q    <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx_q    <= idx_in;
                wdata_q  <= native_wdata;
                wstrb_q  <= native_wstrb;
                wait_cnt <= WAIT_INIT;
            end else if ((state == WAIT) && (wait_cnt != 8'd0)) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
        end
    end

`ifdef NATIVE_RAM_OOR_EN
    logic oor_in, oor_q, req_oor, rd_zero_q;

    assign oor_in  = |(native_addr >> (MEM_ADDR_WIDTH + OFF));
    assign req_oor = (state == IDLE) ? oor_in : oor_q;
    assign ram_we  = req_oor ? '0 : ram_wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            oor_q     <= 1'b0;
            rd_zero_q <= 1'b0;
            oor_err   <= 1'b0;
        end else begin
            if (accept) begin
                oor_q <= oor_in;
            end
            if (mem_en) begin
                rd_zero_q <= req_oor;
                if (req_oor) begin
                    oor_err <= 1'b1;
                end
            end
        end
    end

    assign native_rdata = rd_zero_q ? '0 : ram_rdata;
`else
    assign ram_we       = ram_wstrb;
    assign native_rdata = ram_rdata;
`endif

    native_ram_bytewe #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (MEM_ADDR_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (mem_en),
        .we    (ram_we),
        .addr  (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
